// File: rtl/video_mem_sequencer_pkg.sv
// video_mem_sequencer_pkg
// Shared constants for the SRAM time-multiplexing sequencer. A character time
// is 16 clocks. It holds a CPU slot, a video-RAM fetch slot, a char-ROM fetch
// slot and an idle cycle that carries the CPU advance pulse. The default SRAM
// geometry places video RAM and the character ROM in the shared SRAM.
package video_mem_sequencer_pkg;

    typedef logic [3:0] cycle_t;

    localparam int          DEF_RAM_ADDR_WIDTH = 17;
    localparam logic [16:0] DEF_VRAM_BASE      = 17'h08000;
    localparam logic [16:0] DEF_CHAR_ROM_BASE  = 17'h10800;

    localparam cycle_t CPU_START    = 4'd0;
    localparam cycle_t VRAM_START   = 4'd5;
    localparam cycle_t ROM_START    = 4'd10;
    localparam cycle_t CPU_EN_CYCLE = 4'd15;

endpackage

// File: rtl/video_mem_sequencer.sv
// video_mem_sequencer
// Shares one external SRAM between the CPU and the video fetch path. A
// free-running 4-bit counter splits each 16-clock character time into slots:
//   cycles 0-4   CPU access (read or write)
//   cycles 5-9   video-RAM fetch    (only when video_en was high at cycle 0)
//   cycles 10-14 char-ROM fetch     (only when video_en was high at cycle 0)
//   cycle 15     idle, cpu_en pulse
// Every output is a flop. The counter holds the number of the cycle whose
// outputs are loaded on the next clock edge. As a result, the first edge
// after reset release starts cycle 0.
// Ports:
//   clk, reset_n                      clock and synchronous active-low reset
//   video_en                          enable for the two video fetch slots
//   cpu_addr/cpu_wr_data/cpu_we       CPU request, sampled when cycle 0 starts
//   cpu_en                            one-clock pulse in cycle 15
//   cpu_rd_data                       last byte read by the CPU slot
//   video_addr                        fetch address from the video block
//   video_ram_strobe/video_rom_strobe fetch slot strobes
//   video_data                        last fetched byte
//   ram_addr/ram_data_out/ram_data_oe SRAM address and write data bus
//   ram_data_in                       SRAM read data
//   ram_oe_n/ram_we_n                 active-low SRAM enables
module video_mem_sequencer
    import video_mem_sequencer_pkg::*;
#(
    parameter int                        RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
    parameter logic [RAM_ADDR_WIDTH-1:0] VRAM_BASE      = RAM_ADDR_WIDTH'(DEF_VRAM_BASE),
    parameter logic [RAM_ADDR_WIDTH-1:0] CHAR_ROM_BASE  = RAM_ADDR_WIDTH'(DEF_CHAR_ROM_BASE)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      video_en,
    input  logic [15:0]               cpu_addr,
    input  logic [7:0]                cpu_wr_data,
    input  logic                      cpu_we,
    output logic                      cpu_en,
    output logic [7:0]                cpu_rd_data,
    input  logic [11:0]               video_addr,
    output logic                      video_ram_strobe,
    output logic                      video_rom_strobe,
    output logic [7:0]                video_data,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]                ram_data_out,
    output logic                      ram_data_oe,
    input  logic [7:0]                ram_data_in,
    output logic                      ram_oe_n,
    output logic                      ram_we_n
);

    cycle_t                    cnt_q, cnt_d;
    logic                      cpu_we_q, cpu_we_d;
    logic                      video_act_q, video_act_d;
    logic                      cpu_en_q, cpu_en_d;
    logic [7:0]                cpu_rd_data_q, cpu_rd_data_d;
    logic                      video_ram_strobe_q, video_ram_strobe_d;
    logic                      video_rom_strobe_q, video_rom_strobe_d;
    logic [7:0]                video_data_q, video_data_d;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]                ram_data_out_q, ram_data_out_d;
    logic                      ram_data_oe_q, ram_data_oe_d;
    logic                      ram_oe_n_q, ram_oe_n_d;
    logic                      ram_we_n_q, ram_we_n_d;
    logic [RAM_ADDR_WIDTH-1:0] fetch_addr;

    // Bit 11 of the video address selects the char ROM. Otherwise the fetch
    // goes to video RAM. Any carry past the SRAM width is dropped.
    assign fetch_addr = (video_addr[11] ? CHAR_ROM_BASE : VRAM_BASE)
                        + RAM_ADDR_WIDTH'(video_addr[10:0]);

    // Slot decode. By default the enables and strobes are inactive and the
    // data/address registers hold their values. Each case item loads the
    // outputs for the cycle that the counter names. Read data is captured on
    // the edge that ends the last enable cycle of the access.
    always_comb begin
        cnt_d              = cnt_q + 4'd1;
        cpu_we_d           = cpu_we_q;
        video_act_d        = video_act_q;
        cpu_en_d           = 1'b0;
        cpu_rd_data_d      = cpu_rd_data_q;
        video_ram_strobe_d = 1'b0;
        video_rom_strobe_d = 1'b0;
        video_data_d       = video_data_q;
        ram_addr_d         = ram_addr_q;
        ram_data_out_d     = ram_data_out_q;
        ram_data_oe_d      = 1'b0;
        ram_oe_n_d         = 1'b1;
        ram_we_n_d         = 1'b1;

        case (cnt_q)
            CPU_START: begin
                cpu_we_d       = cpu_we;
                video_act_d    = video_en;
                ram_addr_d     = RAM_ADDR_WIDTH'(cpu_addr);
                ram_data_out_d = cpu_wr_data;
            end
            CPU_START + 4'd1, CPU_START + 4'd2, CPU_START + 4'd3: begin
                if (cpu_we_q) begin
                    ram_we_n_d    = 1'b0;
                    ram_data_oe_d = 1'b1;
                end else begin
                    ram_oe_n_d    = 1'b0;
                end
            end
            CPU_START + 4'd4: begin
                if (!cpu_we_q) begin
                    cpu_rd_data_d = ram_data_in;
                end
            end
            VRAM_START: begin
                video_ram_strobe_d = video_act_q;
            end
            VRAM_START + 4'd1: begin
                video_ram_strobe_d = video_act_q;
                if (video_act_q) begin
                    ram_addr_d = fetch_addr;
                    ram_oe_n_d = 1'b0;
                end
            end
            VRAM_START + 4'd2, VRAM_START + 4'd3: begin
                video_ram_strobe_d = video_act_q;
                ram_oe_n_d         = !video_act_q;
            end
            VRAM_START + 4'd4: begin
                if (video_act_q) begin
                    video_data_d = ram_data_in;
                end
            end
            ROM_START: begin
                video_rom_strobe_d = video_act_q;
            end
            ROM_START + 4'd1: begin
                video_rom_strobe_d = video_act_q;
                if (video_act_q) begin
                    ram_addr_d = fetch_addr;
                    ram_oe_n_d = 1'b0;
                end
            end
            ROM_START + 4'd2, ROM_START + 4'd3: begin
                video_rom_strobe_d = video_act_q;
                ram_oe_n_d         = !video_act_q;
            end
            ROM_START + 4'd4: begin
                if (video_act_q) begin
                    video_data_d = ram_data_in;
                end
            end
            CPU_EN_CYCLE: begin
                cpu_en_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and output registers. Reset aborts any access in progress and
    // restarts the character time from cycle 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q              <= CPU_START;
            cpu_we_q           <= 1'b0;
            video_act_q        <= 1'b0;
            cpu_en_q           <= 1'b0;
            cpu_rd_data_q      <= 8'h00;
            video_ram_strobe_q <= 1'b0;
            video_rom_strobe_q <= 1'b0;
            video_data_q       <= 8'h00;
            ram_addr_q         <= '0;
            ram_data_out_q     <= 8'h00;
            ram_data_oe_q      <= 1'b0;
            ram_oe_n_q         <= 1'b1;
            ram_we_n_q         <= 1'b1;
        end else begin
            cnt_q              <= cnt_d;
            cpu_we_q           <= cpu_we_d;
            video_act_q        <= video_act_d;
            cpu_en_q           <= cpu_en_d;
            cpu_rd_data_q      <= cpu_rd_data_d;
            video_ram_strobe_q <= video_ram_strobe_d;
            video_rom_strobe_q <= video_rom_strobe_d;
            video_data_q       <= video_data_d;
            ram_addr_q         <= ram_addr_d;
            ram_data_out_q     <= ram_data_out_d;
            ram_data_oe_q      <= ram_data_oe_d;
            ram_oe_n_q         <= ram_oe_n_d;
            ram_we_n_q         <= ram_we_n_d;
        end
    end

    assign cpu_en           = cpu_en_q;
    assign cpu_rd_data      = cpu_rd_data_q;
    assign video_ram_strobe = video_ram_strobe_q;
    assign video_rom_strobe = video_rom_strobe_q;
    assign video_data       = video_data_q;
    assign ram_addr         = ram_addr_q;
    assign ram_data_out     = ram_data_out_q;
    assign ram_data_oe      = ram_data_oe_q;
    assign ram_oe_n         = ram_oe_n_q;
    assign ram_we_n         = ram_we_n_q;

endmodule
